// File: rtl/bitplane_serial_tx.sv
`default_nettype none
// ==== bitplane_serial_tx : bank prefetch + bit-plane serial framer | rev 1.0 ====
// Loads NUM_WORDS words, then sends WORD_W frames of {plane index, one bit per word}.
module bitplane_serial_tx #(
  parameter int NUM_WORDS = 18,
  parameter int WORD_W    = 8,
  parameter int RB_AW     = 5,
  parameter int PLANE_AW  = 3,
  parameter int CLK_DIV   = 1,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             lsb_first,
  output logic             busy,
  output logic             done,
  output logic             rb_rw,
  output logic [RB_AW-1:0] rb_a,
  output logic [7:0]       rb_d,
  input  logic [7:0]       rb_q,
  output logic             sen,
  output logic             sd
);

  localparam int IW = $clog2(NUM_WORDS + PLANE_AW + 1);
  localparam int BW = $clog2(NUM_WORDS);
  localparam int DW = $clog2(CLK_DIV + GAP + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]          state, state_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic [DW-1:0]       div, div_nxt;
  logic [PLANE_AW-1:0] plane, plane_nxt;
  logic                lsb, lsb_nxt;
  logic                busy_nxt, done_nxt, sen_nxt, sd_nxt;
  logic [RB_AW-1:0]    rb_a_nxt;
  logic [WORD_W-1:0]   word_buf [NUM_WORDS];
  logic [IW-1:0]       cap_idx;
  logic [IW-1:0]       addr_shift;
  logic [PLANE_AW-1:0] addr_word, bit_sel;
  logic [WORD_W-1:0]   data_word;
  logic                div_last, gap_last;

  assign rb_rw    = 1'b1;
  assign rb_d     = 8'h00;
  assign div_last = (div == DW'(CLK_DIV - 1));
  assign gap_last = (div == DW'(GAP - 1));
  assign cap_idx  = idx - IW'(1);

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      div   <= '0;
      plane <= '0;
      lsb   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      rb_a  <= '0;
      sen   <= 1'b1;
      sd    <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      div   <= div_nxt;
      plane <= plane_nxt;
      lsb   <= lsb_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      rb_a  <= rb_a_nxt;
      sen   <= sen_nxt;
      sd    <= sd_nxt;
    end
  end

  // Bank data for address k arrives one cycle after it is driven; idx leads by one.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && idx != '0)
      word_buf[cap_idx[BW-1:0]] <= rb_q[WORD_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    div_nxt   = div;
    plane_nxt = plane;
    lsb_nxt   = lsb;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          idx_nxt   = '0;
          lsb_nxt   = lsb_first;
        end
      end
      S_LOAD: begin
        idx_nxt = idx + IW'(1);
        if (idx == IW'(NUM_WORDS)) begin
          state_nxt = S_ADDR;
          idx_nxt   = '0;
          div_nxt   = '0;
          plane_nxt = '0;
        end
      end
      S_ADDR: begin
        div_nxt = div + DW'(1);
        if (div_last) begin
          div_nxt = '0;
          if (idx == IW'(PLANE_AW - 1)) begin
            state_nxt = S_DATA;
            idx_nxt   = IW'(NUM_WORDS - 1);
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      S_DATA: begin
        div_nxt = div + DW'(1);
        if (div_last) begin
          div_nxt = '0;
          if (idx == '0) state_nxt = S_GAP;
          else           idx_nxt   = idx - IW'(1);
        end
      end
      S_GAP: begin
        div_nxt = div + DW'(1);
        if (gap_last) begin
          div_nxt = '0;
          if (plane == PLANE_AW'(WORD_W - 1)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ADDR;
            plane_nxt = plane + PLANE_AW'(1);
            idx_nxt   = '0;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt   = (state_nxt == S_LOAD) || (state_nxt == S_ADDR) ||
                 (state_nxt == S_DATA) || (state_nxt == S_GAP);
    done_nxt   = (state_nxt == S_DONE);
    sen_nxt    = !((state_nxt == S_ADDR) || (state_nxt == S_DATA));
    rb_a_nxt   = rb_a;
    if (state_nxt == S_LOAD && idx_nxt < IW'(NUM_WORDS))
      rb_a_nxt = RB_AW'(idx_nxt);
    addr_shift = IW'(PLANE_AW - 1) - idx_nxt;
    addr_word  = plane_nxt >> addr_shift;
    bit_sel    = lsb_nxt ? plane_nxt : PLANE_AW'(WORD_W - 1) - plane_nxt;
    data_word  = word_buf[idx_nxt[BW-1:0]] >> bit_sel;
    sd_nxt     = 1'b0;
    if (state_nxt == S_ADDR)      sd_nxt = addr_word[0];
    else if (state_nxt == S_DATA) sd_nxt = data_word[0];
  end

endmodule
`default_nettype wire

// File: tb/tb_bitplane_serial_tx.sv
`default_nettype none
// Bench for bitplane_serial_tx: cycle-level scoreboard on a default and a small instance.
module tb_bitplane_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, lsb_first = 1'b0;
  logic busy0, done0, rw0, sen0, sd0;
  logic busy1, done1, rw1, sen1, sd1;
  logic [4:0] a0;
  logic [1:0] a1;
  logic [7:0] d0, d1, q0, q1;
  logic [7:0] mem [32];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         inst;
    logic [3:0] ctl;   // {busy, done, sen, sd}
    bit         ck_a;
    logic [7:0] a;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  logic [3:0] mon_ctl;
  logic [7:0] mon_a;

  bitplane_serial_tx u_dut (
    .clk(clk), .rst(rst), .start(start0), .lsb_first(lsb_first),
    .busy(busy0), .done(done0), .rb_rw(rw0), .rb_a(a0), .rb_d(d0), .rb_q(q0),
    .sen(sen0), .sd(sd0)
  );

  bitplane_serial_tx #(
    .NUM_WORDS(4), .WORD_W(4), .RB_AW(2), .PLANE_AW(2), .CLK_DIV(3), .GAP(2)
  ) u_small (
    .clk(clk), .rst(rst), .start(start1), .lsb_first(lsb_first),
    .busy(busy1), .done(done1), .rb_rw(rw1), .rb_a(a1), .rb_d(d1), .rb_q(q1),
    .sen(sen1), .sd(sd1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    q0 <= mem[a0];
    q1 <= mem[a1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int inst, input logic [3:0] ctl, input bit ck, input logic [7:0] a);
    exp_t e;
    e.inst = inst; e.ctl = ctl; e.ck_a = ck; e.a = a;
    sbq.push_back(e);
  endtask

  // Expected per-cycle output stream starting the cycle after the start edge.
  task automatic push_op(input int inst, input logic lsb);
    int n, w, pa, cd, g, bsel;
    logic bv;
    if (inst == 0) begin n = 18; w = 8; pa = 3; cd = 1; g = 1; end
    else           begin n = 4;  w = 4; pa = 2; cd = 3; g = 2; end
    for (int k = 0; k <= n; k++) push(inst, 4'b1010, (k < n), 8'(k));
    for (int p = 0; p < w; p++) begin
      bsel = lsb ? p : w - 1 - p;
      for (int i = pa - 1; i >= 0; i--) begin
        bv = ((p >> i) & 1) != 0;
        repeat (cd) push(inst, {3'b100, bv}, 1'b0, 8'h00);
      end
      for (int j = n - 1; j >= 0; j--) begin
        bv = mem[j][bsel];
        repeat (cd) push(inst, {3'b100, bv}, 1'b0, 8'h00);
      end
      repeat (g) push(inst, 4'b1010, 1'b0, 8'h00);
    end
    push(inst, 4'b0110, 1'b0, 8'h00);
    push(inst, 4'b0010, 1'b0, 8'h00);
  endtask

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done0 : done1;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start0 = v; else start1 = v;
  endtask

  task automatic run_op(input int inst, input logic lsb, input int total, input bit noisy);
    int cnt;
    @(posedge clk); #1;
    set_start(inst, 1'b1);
    lsb_first = lsb;
    @(posedge clk);
    push_op(inst, lsb);
    #1;
    set_start(inst, 1'b0);
    lsb_first = ~lsb;
    cnt = 0;
    while (!get_done(inst) && cnt < total + 20) begin
      if (noisy) begin
        set_start(inst, $urandom_range(0, 2) == 0);
        lsb_first = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      cnt++;
    end
    check("done_latency", cnt, total);
    check("done_pulse", get_done(inst), 1'b1);
    set_start(inst, 1'b1);          // lands in the DONE cycle, must be ignored
    @(posedge clk); #1;
    set_start(inst, 1'b0);
    check("done_width", get_done(inst), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      check("sb_drained", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rb_const", {rw0, d0, rw1, d1}, {1'b1, 8'h00, 1'b1, 8'h00});
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        if (mon_e.inst == 0) begin mon_ctl = {busy0, done0, sen0, sd0}; mon_a = {3'b000, a0}; end
        else                 begin mon_ctl = {busy1, done1, sen1, sd1}; mon_a = {6'b000000, a1}; end
        check(mon_e.inst == 0 ? "cyc_ctl0" : "cyc_ctl1", mon_ctl, mon_e.ctl);
        if (mon_e.ck_a) check(mon_e.inst == 0 ? "cyc_rb_a0" : "cyc_rb_a1", mon_a, mon_e.a);
      end else begin
        check("idle", {busy0, done0, sen0, sd0, busy1, done1, sen1, sd1}, 8'b0010_0010);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 8'hFF;
    for (int j = 1; j < 32; j++) mem[j] = 8'hA5;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl0", {busy0, done0, sen0, sd0}, 4'b0010);
    check("rst_rb0", {rw0, a0, d0}, {1'b1, 5'd0, 8'h00});
    check("rst_ctl1", {busy1, done1, sen1, sd1}, 4'b0010);
    check("rst_rb_a1", a1, 2'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_op(0, 1'b0, 195, 1'b1);
    run_op(0, 1'b1, 195, 1'b0);

    // Reset in the data phase of frame 3
    @(posedge clk); #1;
    start0 = 1'b1; lsb_first = 1'b0;
    @(posedge clk);
    push_op(0, 1'b0);
    #1;
    start0 = 1'b0;
    repeat (94) @(posedge clk);
    #3;
    check("pre_rst_busy_sen", {busy0, sen0}, 2'b10);
    rst = 1'b1;
    #1;
    check("rst_abort", {busy0, done0, sen0, sd0}, 4'b0010);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int j = 0; j < 32; j++) mem[j] = 8'h3C ^ 8'(j * 11);
    run_op(0, 1'b0, 195, 1'b0);

    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h08;
    run_op(1, 1'b0, 85, 1'b1);
    run_op(1, 1'b1, 85, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
